// File: rtl/overture_pkg.sv
// Shared types and constants for the Overture-style core and its ALU.
package overture_pkg;

  typedef enum logic [1:0] {
    M_IMM  = 2'd0,
    M_CALC = 2'd1,
    M_COPY = 2'd2,
    M_COND = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_IO = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [2:0] ALU_OR   = 3'd0;
  localparam logic [2:0] ALU_NAND = 3'd1;
  localparam logic [2:0] ALU_NOR  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_XNOR = 3'd7;

  localparam logic [2:0] CC_NEVER = 3'd0;
  localparam logic [2:0] CC_EQZ   = 3'd1;
  localparam logic [2:0] CC_LTZ   = 3'd2;
  localparam logic [2:0] CC_LEZ   = 3'd3;
  localparam logic [2:0] CC_ALWAYS = 3'd4;
  localparam logic [2:0] CC_NEZ   = 3'd5;
  localparam logic [2:0] CC_GEZ   = 3'd6;
  localparam logic [2:0] CC_GTZ   = 3'd7;

  localparam logic [2:0] IO_SLOT   = 3'd6;
  localparam logic [2:0] NULL_SLOT = 3'd7;
  localparam logic [7:0] OP_HALT   = 8'hBF;

endpackage

// File: rtl/overture_alu_p.sv
// Combinational ALU (r1 op r2) and signed condition test on r3.
module overture_alu_p
  import overture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] test,
  input  logic [2:0]        alu_op,
  input  logic [2:0]        cond,
  output logic [DATA_W-1:0] result,
  output logic              take_jump
);

  logic neg;
  logic zero;

  assign neg  = test[DATA_W-1];
  assign zero = (test == '0);

  // ALU result; ADD/SUB wrap naturally at DATA_W bits
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_OR:   result = a | b;
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_AND:  result = a & b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_XNOR: result = ~(a ^ b);
      default:  result = '0;
    endcase
  end

  // Condition evaluation with r3 treated as two's complement
  always_comb begin
    take_jump = 1'b0;
    case (cond)
      CC_NEVER:  take_jump = 1'b0;
      CC_EQZ:    take_jump = zero;
      CC_LTZ:    take_jump = neg;
      CC_LEZ:    take_jump = neg | zero;
      CC_ALWAYS: take_jump = 1'b1;
      CC_NEZ:    take_jump = ~zero;
      CC_GEZ:    take_jump = ~neg;
      CC_GTZ:    take_jump = ~neg & ~zero;
      default:   take_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/overture_core_p.sv
// Overture-style core: PC, six-entry register file, handshaked I/O port
// and run/halt sequencing. Opcodes come from an external combinational ROM.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | one instruction per cycle
// WAIT_IO | I/O copy stalled on handshake, PC and registers held
// HALT    | halt opcode seen, PC frozen, waiting for start
module overture_core_p
  import overture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [7:0]        instr_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_RUN     = 2'(ST_RUN);
  localparam logic [1:0] S_WAIT_IO = 2'(ST_WAIT_IO);
  localparam logic [1:0] S_HALT    = 2'(ST_HALT);

  logic [1:0]        state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] rf [0:5];

  mode_e             mode;
  logic [2:0]        src;
  logic [2:0]        dst;
  logic              active;
  logic              is_halt;
  logic              rd_io;
  logic              wr_io;
  logic              out_ok;
  logic              done;
  logic              exec;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] alu_result;
  logic              take_jump;

  assign mode    = mode_e'(instr_data[7:6]);
  assign src     = instr_data[5:3];
  assign dst     = instr_data[2:0];
  assign active  = (state == S_RUN) || (state == S_WAIT_IO);
  assign is_halt = (instr_data == OP_HALT);
  assign rd_io   = (mode == M_COPY) && !is_halt && (src == IO_SLOT);
  assign wr_io   = (mode == M_COPY) && !is_halt && (dst == IO_SLOT);
  assign out_ok  = !out_valid || out_ready;
  // An I/O copy completes only when every port it touches is ready
  assign done    = (!rd_io || in_valid) && (!wr_io || out_ok);
  assign exec    = active && !is_halt && done;

  // The input is only offered when the rest of the instruction can complete
  assign in_ready   = active && rd_io && (!wr_io || out_ok);
  assign instr_addr = pc;
  assign halted     = (state == S_HALT);
  assign dbg_state  = state;

  // Copy source select: r0..r5, input port, or constant zero
  always_comb begin
    src_val = '0;
    case (src)
      IO_SLOT:   src_val = in_data;
      NULL_SLOT: src_val = '0;
      default:   src_val = rf[src];
    endcase
  end

  overture_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a         (rf[1]),
    .b         (rf[2]),
    .test      (rf[3]),
    .alu_op    (instr_data[2:0]),
    .cond      (instr_data[2:0]),
    .result    (alu_result),
    .take_jump (take_jump)
  );

  // Register file writes for completed IMM/CALC/COPY instructions
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 6; i++) rf[i] <= '0;
    end else if (exec) begin
      case (mode)
        M_IMM:  rf[0] <= DATA_W'(instr_data[5:0]);
        M_CALC: rf[3] <= alu_result;
        M_COPY: if (dst != IO_SLOT && dst != NULL_SLOT) rf[dst] <= src_val;
        default: ;
      endcase
    end
  end

  // Run/halt sequencing and program counter
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        default: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (done) begin
            state <= S_RUN;
            if (mode == M_COND && take_jump) pc <= PC_W'(rf[0]);
            else                             pc <= pc + PC_W'(1);
          end else begin
            state <= S_WAIT_IO;
          end
        end
      endcase
    end
  end

  // Output port register; a new write wins over a simultaneous drain
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (exec && wr_io) begin
      out_data  <= src_val;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_overture_core_p.sv
// Bench for overture_core_p: directed scenarios plus a randomized run
// against an instruction-level reference model of the 8-bit configuration,
// and a directed run on a 16-bit data / 10-bit PC instance.
module tb_overture_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res, start, start_b;

  logic [7:0] instr_addr, instr_data, in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready, halted;
  logic [1:0] dbg_state;
  logic [7:0] rom [256];
  assign instr_data = rom[instr_addr];

  logic [9:0]  instr_addr_b;
  logic [7:0]  instr_data_b;
  logic [15:0] in_data_b, out_data_b;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, halted_b;
  logic [1:0]  dbg_state_b;
  logic [7:0]  rom_b [1024];
  assign instr_data_b = rom_b[instr_addr_b];

  overture_core_p #(.DATA_W(8), .PC_W(8)) dut (
    .clk(clk), .res(res), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .dbg_state(dbg_state)
  );

  overture_core_p #(.DATA_W(16), .PC_W(10)) dut_b (
    .clk(clk), .res(res), .start(start_b),
    .instr_addr(instr_addr_b), .instr_data(instr_data_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .halted(halted_b), .dbg_state(dbg_state_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state of the 8-bit core
  logic [7:0] m_pc, m_od;
  logic [7:0] m_r [6];
  logic       m_ov;
  int         m_st;   // 0 idle, 1 run, 2 waiting on I/O, 3 halted

  function automatic void model_reset();
    m_pc = 8'd0; m_od = 8'd0; m_ov = 1'b0; m_st = 0;
    for (int i = 0; i < 6; i++) m_r[i] = 8'd0;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] s);
    if (s < 3'd6) return m_r[s];
    if (s == 3'd6) return in_data;
    return 8'd0;
  endfunction

  function automatic logic m_in_ready();
    logic [7:0] op;
    op = rom[m_pc];
    if (m_st != 1 && m_st != 2) return 1'b0;
    if (op[7:6] != 2'b10 || op == 8'hBF || op[5:3] != 3'd6) return 1'b0;
    if (op[2:0] == 3'd6) return !m_ov || out_ready;
    return 1'b1;
  endfunction

  // Execute one cycle of the instruction set semantics with current inputs
  function automatic void model_step();
    logic [7:0] op, v, a, b;
    logic ov_next, ok, jmp, rdi, wro;
    int t;
    op = rom[m_pc];
    ov_next = m_ov && !out_ready;
    if (m_st == 0 || m_st == 3) begin
      if (start) begin m_st = 1; m_pc = 8'd0; end
    end else if (op == 8'hBF) begin
      m_st = 3;
    end else begin
      case (op[7:6])
        2'b00: begin m_r[0] = {2'b00, op[5:0]}; m_pc = m_pc + 8'd1; m_st = 1; end
        2'b01: begin
          a = m_r[1]; b = m_r[2];
          case (op[2:0])
            3'd0: v = a | b;     3'd1: v = ~(a & b);
            3'd2: v = ~(a | b);  3'd3: v = a & b;
            3'd4: v = a + b;     3'd5: v = a - b;
            3'd6: v = a ^ b;     default: v = ~(a ^ b);
          endcase
          m_r[3] = v; m_pc = m_pc + 8'd1; m_st = 1;
        end
        2'b10: begin
          rdi = (op[5:3] == 3'd6);
          wro = (op[2:0] == 3'd6);
          ok = (!rdi || in_valid) && (!wro || !m_ov || out_ready);
          if (ok) begin
            v = m_read(op[5:3]);
            if (op[2:0] < 3'd6) m_r[op[2:0]] = v;
            else if (wro) begin m_od = v; ov_next = 1'b1; end
            m_pc = m_pc + 8'd1; m_st = 1;
          end else begin
            m_st = 2;
          end
        end
        default: begin
          t = int'($signed(m_r[3]));
          case (op[2:0])
            3'd0: jmp = 1'b0;     3'd1: jmp = (t == 0);
            3'd2: jmp = (t < 0);  3'd3: jmp = (t <= 0);
            3'd4: jmp = 1'b1;     3'd5: jmp = (t != 0);
            3'd6: jmp = (t >= 0); default: jmp = (t > 0);
          endcase
          m_pc = jmp ? m_r[0] : m_pc + 8'd1;
          m_st = 1;
        end
      endcase
    end
    m_ov = ov_next;
  endfunction

  // One clock of DUT A with the model advanced on the same inputs
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic void rom_fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = 8'hBF;
  endfunction

  task automatic test_reset();
    res = 1'b1;
    #1;
    checks++; if (instr_addr !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", instr_addr); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin errors++; $display("FAIL reset_out: got v=%0b d=%0h expected v=0 d=0", out_valid, out_data); end
    checks++; if (dbg_state !== 2'd0 || halted !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reset_state: got st=%0d h=%0b ir=%0b expected 0 0 0", dbg_state, halted, in_ready); end
    repeat (2) @(posedge clk);
    #3;
    res = 1'b0;
    model_reset();
    rom[0] = 8'hB0;
    tick(); tick();
    checks++; if (dbg_state !== 2'd0 || instr_addr !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL idle_hold: got st=%0d pc=%0h ir=%0b expected 0 0 0", dbg_state, instr_addr, in_ready); end
  endtask

  task automatic test_program();
    rom_fill_halt();
    rom[0] = 8'h05; rom[1] = 8'h81; rom[2] = 8'h07; rom[3] = 8'h82;
    rom[4] = 8'h44; rom[5] = 8'h9E; rom[6] = 8'hBF;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (dbg_state !== 2'd1 || instr_addr !== 8'd0) begin errors++; $display("FAIL start_run: got st=%0d pc=%0h expected 1 0", dbg_state, instr_addr); end
    repeat (6) tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'd12 || instr_addr !== 8'd6) begin errors++; $display("FAIL add_out: got v=%0b d=%0d pc=%0h expected v=1 d=12 pc=6", out_valid, out_data, instr_addr); end
    tick();
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || instr_addr !== 8'd6) begin errors++; $display("FAIL halt: got v=%0b h=%0b pc=%0h expected 0 1 6", out_valid, halted, instr_addr); end
    start = 1'b0; tick();
    checks++; if (halted !== 1'b1 || instr_addr !== 8'd6 || dbg_state !== 2'd3) begin errors++; $display("FAIL halt_hold: got h=%0b pc=%0h st=%0d expected 1 6 3", halted, instr_addr, dbg_state); end
  endtask

  task automatic test_sub_cond();
    rom_fill_halt();
    rom[0] = 8'h03; rom[1] = 8'h81; rom[2] = 8'h05; rom[3] = 8'h82;
    rom[4] = 8'h45; rom[5] = 8'h10; rom[6] = 8'hC2;
    rom[8'h10] = 8'hC7; rom[8'h11] = 8'h9E; rom[8'h12] = 8'hBF;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    checks++; if (instr_addr !== 8'h10) begin errors++; $display("FAIL cond_ltz_taken: got %0h expected 10", instr_addr); end
    tick();
    checks++; if (instr_addr !== 8'h11) begin errors++; $display("FAIL cond_gtz_not_taken: got %0h expected 11", instr_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin errors++; $display("FAIL sub_wrap: got v=%0b d=%0h expected v=1 d=fe", out_valid, out_data); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sub_halt: got %0b expected 1", halted); end
  endtask

  task automatic test_input_stall();
    rom_fill_halt();
    rom[0] = 8'hB0; rom[1] = 8'h9E; rom[2] = 8'hBF;
    rom[1] = 8'h86;
    in_valid = 1'b0; in_data = 8'h33; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (dbg_state !== 2'd2 || instr_addr !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL in_stall%0d: got st=%0d pc=%0h ir=%0b expected 2 0 1", i, dbg_state, instr_addr, in_ready); end
    end
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    checks++; if (dbg_state !== 2'd1 || instr_addr !== 8'd1) begin errors++; $display("FAIL in_done: got st=%0d pc=%0h expected 1 1", dbg_state, instr_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL in_value: got v=%0b d=%0h expected v=1 d=5a", out_valid, out_data); end
    tick();
  endtask

  task automatic test_backpressure();
    rom_fill_halt();
    rom[0] = 8'h05; rom[1] = 8'h86; rom[2] = 8'h07; rom[3] = 8'h86;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dbg_state !== 2'd2 || instr_addr !== 8'd3 || out_data !== 8'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL out_stall%0d: got st=%0d pc=%0h d=%0d v=%0b expected 2 3 5 1", i, dbg_state, instr_addr, out_data, out_valid); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 8'd7 || out_valid !== 1'b1 || instr_addr !== 8'd4 || dbg_state !== 2'd1) begin errors++; $display("FAIL out_accept_write: got d=%0d v=%0b pc=%0h st=%0d expected 7 1 4 1", out_data, out_valid, instr_addr, dbg_state); end
    tick();
    checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL out_drain: got v=%0b h=%0b expected 0 1", out_valid, halted); end
  endtask

  task automatic test_reset_mid_wait();
    rom_fill_halt();
    rom[0] = 8'h05; rom[1] = 8'h86; rom[2] = 8'hB0;
    in_valid = 1'b0; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b0;
    repeat (4) tick();
    checks++; if (dbg_state !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_wait: got st=%0d v=%0b expected 2 1", dbg_state, out_valid); end
    #2 res = 1'b1;
    #1;
    checks++; if (instr_addr !== 8'd0 || out_valid !== 1'b0 || out_data !== 8'd0 || dbg_state !== 2'd0 || halted !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc=%0h v=%0b d=%0h st=%0d h=%0b ir=%0b expected all 0", instr_addr, out_valid, out_data, dbg_state, halted, in_ready);
    end
    model_reset();
    #3 res = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (dbg_state !== 2'd1 || instr_addr !== 8'd0) begin errors++; $display("FAIL restart: got st=%0d pc=%0h expected 1 0", dbg_state, instr_addr); end
    tick();
    checks++; if (instr_addr !== 8'd1) begin errors++; $display("FAIL restart_step: got %0h expected 1", instr_addr); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       rom[i] = 8'hBF;
      else if (r < 18) rom[i] = {2'b10, 3'd6, 3'($urandom_range(0, 7))};
      else if (r < 33) rom[i] = {2'b10, 3'($urandom_range(0, 7)), 3'd6};
      else             rom[i] = 8'($urandom);
    end
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      in_data   = 8'($urandom);
      start     = ($urandom_range(0, 99) < 5);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready@%0d: got %0b expected %0b", c, in_ready, m_in_ready()); end
      tick();
      checks++; if (instr_addr !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %0h expected %0h", c, instr_addr, m_pc); end
      checks++; if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin errors++; $display("FAIL rnd_out@%0d: got v=%0b d=%0h expected v=%0b d=%0h", c, out_valid, out_data, m_ov, m_od); end
      checks++; if (dbg_state !== 2'(m_st) || halted !== (m_st == 3)) begin errors++; $display("FAIL rnd_state@%0d: got st=%0d h=%0b expected st=%0d", c, dbg_state, halted, m_st); end
    end
    start = 1'b0;
  endtask

  task automatic test_wide();
    logic [15:0] got [$];
    int n;
    for (int i = 0; i < 1024; i++) rom_b[i] = 8'hBF;
    rom_b[0] = 8'h3F; rom_b[1] = 8'hC4;
    rom_b[10'h3F] = 8'h42; rom_b[10'h40] = 8'h99; rom_b[10'h41] = 8'h8E;
    rom_b[10'h42] = 8'h01; rom_b[10'h43] = 8'h82; rom_b[10'h44] = 8'h44;
    rom_b[10'h45] = 8'h9E; rom_b[10'h46] = 8'hBF;
    out_ready_b = 1'b1;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_addr_b !== 10'h03F) begin errors++; $display("FAIL wide_jump: got %0h expected 03f", instr_addr_b); end
    n = 0;
    while (!halted_b && n < 40) begin
      @(posedge clk); #1; n++;
      if (out_valid_b) got.push_back(out_data_b);
    end
    checks++; if (!halted_b) begin errors++; $display("FAIL wide_timeout: got halted=%0b expected 1", halted_b); end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL wide_count: got %0d outputs expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== 16'hFFFF) begin errors++; $display("FAIL wide_nor: got %0h expected ffff", got[0]); end
      checks++; if (got[1] !== 16'h0000) begin errors++; $display("FAIL wide_add_wrap: got %0h expected 0", got[1]); end
    end
    checks++; if (instr_addr_b !== 10'h046) begin errors++; $display("FAIL wide_halt_pc: got %0h expected 046", instr_addr_b); end
  endtask

  initial begin
    res = 1'b0; start = 1'b0; start_b = 1'b0;
    in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    in_data_b = 16'd0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    rom_fill_halt();
    for (int i = 0; i < 1024; i++) rom_b[i] = 8'hBF;
    model_reset();
    #2;
    test_reset();
    test_program();
    test_sub_cond();
    test_input_stall();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
